// File: rtl/imm_gen_pkg.sv
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic [$clog2(SKID_DEPTH + 1)-1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_t;

endpackage

// File: rtl/imm_gen_pipe_format_decode.sv
module imm_format_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter bit          RV64 = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  // Every format is first built as a 32-bit signed value, then widened to XLEN.
  logic signed [31:0] raw;

  always_comb begin
    raw = '0;
    fmt = FMT_NONE;
    unique case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        fmt = FMT_I;
        raw = {{20{instr[31]}}, instr[31:20]};
      end
      OP_IMM_32: begin
        if (RV64) begin
          fmt = FMT_I;
          raw = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        fmt = FMT_S;
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        raw = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt = FMT_J;
        raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_OP: begin
        fmt = FMT_R;
      end
      OP_32: begin
        if (RV64) begin
          fmt = FMT_R;
        end
      end
      default: begin
        fmt = FMT_NONE;
      end
    endcase
  end

  assign imm     = XLEN'(raw);
  assign illegal = (fmt == FMT_NONE) || (instr[1:0] != 2'b11);

endmodule

// File: rtl/imm_gen_pipe.sv
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter bit          RV64 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output fmt_t            out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  fmt_t            dec_fmt;
  logic            dec_illegal;

  imm_format_decode #(
    .XLEN (XLEN),
    .RV64 (RV64)
  ) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_target = in_pc + dec_imm;

  occ_t state, state_nxt;
  logic accept, drain;
  logic load_main, load_skid, shift_skid;

  logic [XLEN-1:0] main_imm, main_target, skid_imm, skid_target;
  fmt_t            main_fmt, skid_fmt;
  logic            main_illegal, skid_illegal;

  assign in_ready  = (state != OCC_FULL);
  assign out_valid = (state != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main always holds the oldest entry; skid is only written while main is
  // stalled, and refills main when it drains.
  always_comb begin
    state_nxt  = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      unique case (state)
        OCC_EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_nxt = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = OCC_FULL;
          end else if (drain) begin
            state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (drain) begin
            shift_skid = 1'b1;
            state_nxt  = OCC_ONE;
          end
        end
        default: begin
          state_nxt = OCC_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm     <= '0;
      main_target  <= '0;
      main_fmt     <= FMT_NONE;
      main_illegal <= 1'b0;
      skid_imm     <= '0;
      skid_target  <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
    end else begin
      if (load_main) begin
        main_imm     <= dec_imm;
        main_target  <= dec_target;
        main_fmt     <= dec_fmt;
        main_illegal <= dec_illegal;
      end else if (shift_skid) begin
        main_imm     <= skid_imm;
        main_target  <= skid_target;
        main_fmt     <= skid_fmt;
        main_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_imm     <= dec_imm;
        skid_target  <= dec_target;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
      end
    end
  end

  assign out_imm     = main_imm;
  assign out_target  = main_target;
  assign out_fmt     = main_fmt;
  assign out_illegal = main_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_imm, out_target;
  fmt_t        out_fmt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_in_pc, b_out_imm, b_out_target;
  fmt_t        b_out_fmt;

  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(64), .RV64(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .RV64(1'b0)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_target(b_out_target), .out_illegal(b_out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] imm;
    fmt_t        fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: immediate value assembled arithmetically from the field weights.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
    exp_t   e;
    longint v;
    longint sgn;
    sgn   = i[31] ? 64'sd1 : 64'sd0;
    v     = 0;
    e.ill = 1'b0;
    e.fmt = FMT_NONE;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0011011: begin
        e.fmt = FMT_I;
        v = longint'(i[31:20]) - sgn * 4096;
      end
      7'b0100011: begin
        e.fmt = FMT_S;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]) - sgn * 4096;
      end
      7'b1100011: begin
        e.fmt = FMT_B;
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2 - sgn * 4096;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = FMT_U;
        v = longint'(i[31:12]) * 4096 - sgn * (longint'(1) << 32);
      end
      7'b1101111: begin
        e.fmt = FMT_J;
        v = longint'(i[30:21]) * 2 + longint'(i[20]) * 2048 + longint'(i[19:12]) * 4096
            - sgn * (longint'(1) << 20);
      end
      7'b0110011, 7'b0111011: e.fmt = FMT_R;
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v);
    e.tgt = pc + 64'(v);
    return e;
  endfunction

  // Scoreboard monitor: occupancy, stall stability and FIFO-ordered contents.
  logic        prev_hold = 1'b0;
  logic [63:0] prev_imm, prev_tgt;
  logic [2:0]  prev_fmt;
  logic        prev_ill;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      chk("occ_out_valid", out_valid, q.size() > 0);
      chk("occ_in_ready", in_ready, q.size() < 2);
      if (prev_hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_imm", out_imm, prev_imm);
        chk("stall_tgt", out_target, prev_tgt);
        chk("stall_fmt", out_fmt, prev_fmt);
        chk("stall_ill", out_illegal, prev_ill);
      end
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_imm", out_imm, e.imm);
          chk("sb_fmt", out_fmt, e.fmt);
          chk("sb_target", out_target, e.tgt);
          chk("sb_illegal", out_illegal, e.ill);
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_imm  = out_imm;
      prev_tgt  = out_target;
      prev_fmt  = out_fmt;
      prev_ill  = out_illegal;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
    end
  end

  task automatic send(input logic [31:0] i, input logic [63:0] p);
    int n = 0;
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = p;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string nm, input logic [31:0] i, input logic [63:0] p,
                          input logic [63:0] eimm, input logic [2:0] efmt,
                          input logic [63:0] etgt, input logic eill);
    send(i, p);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_imm"}, out_imm, eimm);
    chk({nm, "_fmt"}, out_fmt, efmt);
    chk({nm, "_target"}, out_target, etgt);
    chk({nm, "_illegal"}, out_illegal, eill);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_imm"}, out_imm, 0);
    chk({nm, "_target"}, out_target, 0);
    chk({nm, "_fmt"}, out_fmt, FMT_NONE);
    chk({nm, "_illegal"}, out_illegal, 0);
  endtask

  logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0011011,
                           7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b0110011, 7'b0111011};

  initial begin
    int n;
    logic [31:0] r;
    logic [6:0]  opc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_instr = '0; b_in_pc = '0;

    @(posedge clk); #1;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_chk("addi", 32'hFFF00093, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 64'hFFF, 1'b0);
    send_chk("sw", 32'h0020A423, 64'h2000, 64'h8, FMT_S, 64'h2008, 1'b0);
    send_chk("beq", 32'hFE000EE3, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 64'hFC, 1'b0);
    send_chk("lui", 32'h123450B7, 64'h0, 64'h12345000, FMT_U, 64'h12345000, 1'b0);
    send_chk("jal", 32'h001000EF, 64'h0, 64'h800, FMT_J, 64'h800, 1'b0);
    send_chk("bad7f", 32'h0000007F, 64'h40, 64'h0, FMT_NONE, 64'h40, 1'b1);
    send_chk("bad92", 32'h00000092, 64'h44, 64'h0, FMT_NONE, 64'h44, 1'b1);
    send_chk("addiw", 32'h0010009B, 64'h0, 64'h1, FMT_I, 64'h1, 1'b0);

    // 32-bit, RV64=0 instance
    b_in_valid = 1'b1; b_in_instr = 32'h0000001B; b_in_pc = 32'h40;
    @(posedge clk); #1;
    b_in_instr = 32'hFFF00093; b_in_pc = 32'h10;
    @(negedge clk);
    chk("rv32_1b_valid", b_out_valid, 1);
    chk("rv32_1b_illegal", b_out_illegal, 1);
    chk("rv32_1b_fmt", b_out_fmt, FMT_NONE);
    chk("rv32_1b_imm", b_out_imm, 0);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("rv32_addi_imm", b_out_imm, 32'hFFFF_FFFF);
    chk("rv32_addi_fmt", b_out_fmt, FMT_I);
    chk("rv32_addi_target", b_out_target, 32'hF);
    chk("rv32_addi_illegal", b_out_illegal, 0);
    @(posedge clk); #1;

    // Back-to-back with downstream stalled for 3 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h10;
    @(posedge clk); #1;
    in_instr = 32'h00200093; in_pc = 64'h20;
    @(posedge clk); #1;
    in_instr = 32'h00300093; in_pc = 64'h30;
    @(posedge clk); #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_imm", out_imm, 64'h1);
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("bp_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Flush while full with an instruction offered in the same cycle
    out_ready = 1'b0;
    send(32'h00400093, 64'h0);
    send(32'h00500093, 64'h0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 64'h0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset pulse mid-stream
    out_ready = 1'b0;
    send(32'h00600093, 64'h0);
    send(32'h0020A423, 64'h8);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r   = $urandom;
      opc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_instr  = {r[31:7], opc};
      in_pc     = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("final_drained", 64'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
